// File: rtl/nn_class_decider.sv
// Output-layer consumer: collects NUM_CLASSES scores, tracks the running argmax,
// and hands the winning class downstream over a valid/ready handshake.
module nn_class_decider #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 7,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] score_in,
    input  logic              score_stb,
    input  logic              clr,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              class_valid,
    input  logic              class_ready,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_score,
    output logic              overrun,
    output logic [7:0]        vec_count
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] run_max;
    logic [IDX_W-1:0]  run_idx;
    logic [DATA_W-1:0] work_buf [NUM_CLASSES];
    logic [DATA_W-1:0] read_buf [NUM_CLASSES];

    logic              take, last;
    logic [DATA_W-1:0] cand_max;
    logic [IDX_W-1:0]  cand_idx;
    logic              load_result, accept, drop;
    logic [DATA_W-1:0] rd_val;

    // clr beats a simultaneous strobe; the first sample of a vector seeds the max.
    always_comb begin
        take     = score_stb && !clr;
        last     = take && (cnt == IDX_W'(NUM_CLASSES - 1));
        cand_max = run_max;
        cand_idx = run_idx;
        if (cnt == '0) begin
            cand_max = score_in;
            cand_idx = '0;
        end else if (score_in > run_max) begin
            cand_max = score_in;
            cand_idx = cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            run_max <= '0;
            run_idx <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) work_buf[i] <= '0;
        end else if (clr) begin
            cnt     <= '0;
            run_max <= '0;
            run_idx <= '0;
        end else if (take) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                if (cnt == IDX_W'(i)) work_buf[i] <= score_in;
            run_max <= cand_max;
            run_idx <= cand_idx;
            cnt     <= last ? '0 : cnt + IDX_W'(1);
        end
    end

    // The snapshot includes the sample arriving on the completing edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) read_buf[i] <= '0;
        end else if (last) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                read_buf[i] <= (cnt == IDX_W'(i)) ? score_in : work_buf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (last) state_next = HOLD;
            HOLD: if (class_ready && !last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        class_valid = (state == HOLD);
        accept      = (state == HOLD) && class_ready;
        load_result = last && ((state == IDLE) || class_ready);
        drop        = last && (state == HOLD) && !class_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            class_idx   <= '0;
            class_score <= '0;
            overrun     <= 1'b0;
            vec_count   <= '0;
        end else begin
            if (load_result) begin
                class_idx   <= cand_idx;
                class_score <= cand_max;
            end
            if (drop)   overrun   <= 1'b1;
            if (accept) vec_count <= vec_count + 8'd1;
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_CLASSES; i++)
            if (rd_idx == IDX_W'(i)) rd_val = read_buf[i];
    end

    always_ff @(posedge clk) begin
        if (!rst) rd_score <= '0;
        else      rd_score <= rd_val;
    end

endmodule

// File: tb/tb_nn_class_decider.sv
// Directed self-checking bench for nn_class_decider; expectations are hand-computed.
module tb_nn_class_decider;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] score_in;
    logic       score_stb;
    logic       clr;
    logic [3:0] class_idx;
    logic [6:0] class_score;
    logic       class_valid;
    logic       class_ready;
    logic [3:0] rd_idx;
    logic [6:0] rd_score;
    logic       overrun;
    logic [7:0] vec_count;

    int checks = 0;
    int errors = 0;
    logic [6:0] vec [10];

    nn_class_decider #(.NUM_CLASSES(10), .DATA_W(7), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .score_in(score_in), .score_stb(score_stb), .clr(clr),
        .class_idx(class_idx), .class_score(class_score), .class_valid(class_valid),
        .class_ready(class_ready), .rd_idx(rd_idx), .rd_score(rd_score),
        .overrun(overrun), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] v);
        score_in  = v;
        score_stb = 1'b1;
        tick();
        score_stb = 1'b0;
    endtask

    // Strobes vec[lo..hi] with one idle cycle between strobes, none after the last.
    task automatic sendRange(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vec[i]);
            if (i != hi) tick();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; score_in = '0; score_stb = 1'b0; clr = 1'b0;
        class_ready = 1'b0; rd_idx = '0;
        tick(); tick();
        checkOutput("rst_valid", 32'(class_valid), 0);
        checkOutput("rst_idx", 32'(class_idx), 0);
        checkOutput("rst_score", 32'(class_score), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        checkOutput("rst_vec_count", 32'(vec_count), 0);
        checkOutput("rst_rd_score", 32'(rd_score), 0);
        rst = 1'b1;
        tick();

        $display("[TB] basic vector with tie");
        class_ready = 1'b1;
        vec = '{7'd5, 7'd9, 7'd3, 7'd120, 7'd7, 7'd120, 7'd0, 7'd1, 7'd2, 7'd4};
        sendRange(0, 8);
        tick();
        checkOutput("t1_valid_before", 32'(class_valid), 0);
        applyStimulus(vec[9]);
        checkOutput("t1_valid", 32'(class_valid), 1);
        checkOutput("t1_idx", 32'(class_idx), 3);
        checkOutput("t1_score", 32'(class_score), 120);
        rd_idx = 4'd3;
        tick();
        checkOutput("t1_vec_count", 32'(vec_count), 1);
        checkOutput("t1_valid_after", 32'(class_valid), 0);
        checkOutput("t1_rd_score", 32'(rd_score), 120);

        $display("[TB] overrun while held");
        class_ready = 1'b0;
        vec = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60, 7'd70, 7'd100, 7'd80, 7'd90};
        sendRange(0, 9);
        checkOutput("t2_valid", 32'(class_valid), 1);
        checkOutput("t2_idx", 32'(class_idx), 7);
        checkOutput("t2_score", 32'(class_score), 100);
        checkOutput("t2_overrun_before", 32'(overrun), 0);
        tick();
        vec = '{7'd5, 7'd6, 7'd50, 7'd7, 7'd8, 7'd9, 7'd10, 7'd11, 7'd12, 7'd13};
        sendRange(0, 9);
        checkOutput("t2_overrun", 32'(overrun), 1);
        checkOutput("t2_idx_kept", 32'(class_idx), 7);
        checkOutput("t2_score_kept", 32'(class_score), 100);
        checkOutput("t2_valid_kept", 32'(class_valid), 1);
        rd_idx = 4'd2;
        tick();
        checkOutput("t2_rd_score", 32'(rd_score), 50);

        $display("[TB] completion coincident with accept");
        vec = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd60, 7'd9};
        sendRange(0, 8);
        tick();
        class_ready = 1'b1;
        applyStimulus(vec[9]);
        checkOutput("t3_valid", 32'(class_valid), 1);
        checkOutput("t3_idx", 32'(class_idx), 8);
        checkOutput("t3_score", 32'(class_score), 60);
        checkOutput("t3_vec_count", 32'(vec_count), 2);
        tick();
        checkOutput("t3_vec_count_accept", 32'(vec_count), 3);
        checkOutput("t3_valid_after", 32'(class_valid), 0);

        $display("[TB] clr discards partial vector");
        vec = '{7'd127, 7'd127, 7'd127, 7'd127, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        sendRange(0, 3);
        tick();
        clr = 1'b1;
        applyStimulus(7'd127);
        clr = 1'b0;
        tick();
        vec = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd88};
        sendRange(0, 8);
        tick();
        checkOutput("t4_valid_before", 32'(class_valid), 0);
        applyStimulus(vec[9]);
        checkOutput("t4_valid", 32'(class_valid), 1);
        checkOutput("t4_idx", 32'(class_idx), 9);
        checkOutput("t4_score", 32'(class_score), 88);
        rd_idx = 4'd0;
        tick();
        checkOutput("t4_vec_count", 32'(vec_count), 4);
        checkOutput("t4_rd_score", 32'(rd_score), 1);
        checkOutput("t4_overrun_sticky", 32'(overrun), 1);

        $display("[TB] reset mid-vector with result held");
        class_ready = 1'b0;
        vec = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd77};
        sendRange(0, 9);
        checkOutput("t5_held_idx", 32'(class_idx), 9);
        tick();
        vec = '{7'd30, 7'd31, 7'd32, 7'd33, 7'd34, 7'd35, 7'd0, 7'd0, 7'd0, 7'd0};
        sendRange(0, 5);
        rst = 1'b0;
        tick();
        checkOutput("t5_rst_valid", 32'(class_valid), 0);
        checkOutput("t5_rst_idx", 32'(class_idx), 0);
        checkOutput("t5_rst_score", 32'(class_score), 0);
        checkOutput("t5_rst_overrun", 32'(overrun), 0);
        checkOutput("t5_rst_vec_count", 32'(vec_count), 0);
        checkOutput("t5_rst_rd_score", 32'(rd_score), 0);
        rst = 1'b1;
        tick();
        vec = '{7'd9, 7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
        sendRange(0, 8);
        tick();
        checkOutput("t5_valid_before", 32'(class_valid), 0);
        applyStimulus(vec[9]);
        checkOutput("t5_valid", 32'(class_valid), 1);
        checkOutput("t5_idx", 32'(class_idx), 0);
        checkOutput("t5_score", 32'(class_score), 9);
        class_ready = 1'b1;
        tick();
        checkOutput("t5_vec_count", 32'(vec_count), 1);
        class_ready = 1'b0;

        $display("[TB] out-of-range read and all-zero vector");
        rd_idx = 4'd12;
        tick();
        checkOutput("t6_rd_oob", 32'(rd_score), 0);
        rd_idx = 4'd0;
        tick();
        checkOutput("t6_rd_slot0", 32'(rd_score), 9);
        vec = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        sendRange(0, 9);
        checkOutput("t6_valid", 32'(class_valid), 1);
        checkOutput("t6_idx", 32'(class_idx), 0);
        checkOutput("t6_score", 32'(class_score), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
